// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, FSM states,
// immediate extraction helpers and the next-PC decision record.
package ifetch_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_STALL,
    S_DRAIN
  } state_t;

  // Outcome of pre-decoding one returned instruction word.
  typedef struct packed {
    word_t next_pc;
    logic  pred_taken;
    logic  is_jalr;
  } nextpc_t;

  // J-type immediate, 21 bits sign-extended to XLEN.
  function automatic word_t imm_j(input word_t inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, 13 bits sign-extended to XLEN.
  function automatic word_t imm_b(input word_t inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bundle of the fetch stage's icache, predictor, instruction-queue and
// redirect signals; master is the fetch stage, slave is its surroundings.
interface ifetch_if;
  import ifetch_pkg::*;

  // icache request/response
  logic  icache_req;
  word_t icache_addr;
  logic  icache_valid;
  word_t icache_inst;

  // branch predictor query
  word_t query_pc;
  logic  predict_result;

  // instruction queue output slot
  logic  inst_valid;
  logic  inst_ready;
  word_t inst;
  word_t inst_pc;
  logic  inst_pred_taken;

  // ROB redirect
  logic  flush;
  word_t flush_pc;

  modport master (
    output icache_req, icache_addr, query_pc,
    output inst_valid, inst, inst_pc, inst_pred_taken,
    input  icache_valid, icache_inst, predict_result,
    input  inst_ready, flush, flush_pc
  );

  modport slave (
    input  icache_req, icache_addr, query_pc,
    input  inst_valid, inst, inst_pc, inst_pred_taken,
    output icache_valid, icache_inst, predict_result,
    output inst_ready, flush, flush_pc
  );

endinterface

// File: rtl/ifetch_nextpc.sv
// Combinational pre-decode: picks the next fetch PC and predicted direction
// from the fetch PC, the returned word and the predictor's answer.
module ifetch_nextpc
  import ifetch_pkg::*;
(
  input  word_t   pc_i,
  input  word_t   inst_i,
  input  logic    predict_i,
  output nextpc_t res_o
);

  word_t pc_seq;
  word_t pc_jal;
  word_t pc_br;

  // All adds wrap modulo 2^XLEN by construction.
  assign pc_seq = pc_i + word_t'(4);
  assign pc_jal = pc_i + imm_j(inst_i);
  assign pc_br  = pc_i + imm_b(inst_i);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave it unassigned and infer a latch.
    res_o.next_pc    = pc_seq;
    res_o.pred_taken = 1'b0;
    res_o.is_jalr    = 1'b0;
    case (inst_i[6:0])
      OP_JAL: begin
        res_o.next_pc    = pc_jal;
        res_o.pred_taken = 1'b1;
      end
      OP_BRANCH: begin
        res_o.next_pc    = predict_i ? pc_br : pc_seq;
        res_o.pred_taken = predict_i;
      end
      OP_JALR: begin
        // Target unknown until the ROB resolves it; hold the PC.
        res_o.next_pc = pc_i;
        res_o.is_jalr = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: one request in flight, a single output slot, and
// a redirect path from the ROB that may leave one stale response to drain.
module ifetch
  import ifetch_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  ifetch_if.master bus
);

  state_t  state_q;
  word_t   pc_q;
  logic    jalr_pend_q;
  logic    inst_valid_q;
  word_t   inst_q;
  word_t   inst_pc_q;
  logic    pred_q;
  nextpc_t np;

  ifetch_nextpc u_nextpc (
    .pc_i      (pc_q),
    .inst_i    (bus.icache_inst),
    .predict_i (bus.predict_result),
    .res_o     (np)
  );

  assign bus.icache_req      = (state_q == S_FETCH) && rdy && !bus.flush;
  assign bus.icache_addr     = pc_q;
  assign bus.query_pc        = pc_q;
  assign bus.inst_valid      = inst_valid_q;
  assign bus.inst            = inst_q;
  assign bus.inst_pc         = inst_pc_q;
  assign bus.inst_pred_taken = pred_q;

  // NOTE: all registered state uses non-blocking assignments so each flop sees the values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      jalr_pend_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      pred_q       <= 1'b0;
    end else if (rdy) begin
      if (bus.flush) begin
        pc_q         <= bus.flush_pc;
        inst_valid_q <= 1'b0;
        jalr_pend_q  <= 1'b0;
        // A request still unanswered will produce one response to throw away.
        state_q      <= (state_q == S_WAIT && !bus.icache_valid) ? S_DRAIN : S_FETCH;
      end else begin
        case (state_q)
          S_FETCH: state_q <= S_WAIT;
          S_WAIT: begin
            if (bus.icache_valid) begin
              inst_q       <= bus.icache_inst;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              pred_q       <= np.pred_taken;
              jalr_pend_q  <= np.is_jalr;
              pc_q         <= np.next_pc;
              state_q      <= S_SEND;
            end
          end
          S_SEND: begin
            if (bus.inst_ready) begin
              inst_valid_q <= 1'b0;
              state_q      <= jalr_pend_q ? S_STALL : S_FETCH;
            end
          end
          S_STALL: begin
          end
          S_DRAIN: begin
            if (bus.icache_valid) state_q <= S_FETCH;
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a transaction-level reference model that is
// compared against the DUT on every cycle out of reset.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] ADDI1    = 32'h00100093;
  localparam logic [31:0] ADDI2    = 32'h00200113;
  localparam logic [31:0] JALR1    = 32'h000080e7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  ifetch_if bus ();

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] imm_tab [logic [31:0]];

  // Reference model: fetch PC, slot contents and what the stage is waiting for.
  logic [31:0] m_pc, m_inst, m_inst_pc, m_npc;
  logic        m_slot, m_pred, m_can_req, m_wait, m_stale, m_jalr, m_tk, m_jl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  // Control-flow rules: the immediate comes from the table filled when encoding.
  function automatic void model_next(input logic [31:0] pc, input logic [31:0] word,
                                     input logic pred_in, output logic [31:0] npc,
                                     output logic taken, output logic jalr);
    logic [31:0] imm;
    imm   = imm_tab.exists(word) ? imm_tab[word] : 32'h0;
    npc   = pc + 32'd4;
    taken = 1'b0;
    jalr  = 1'b0;
    if (word[6:0] == 7'b1101111) begin
      npc   = pc + imm;
      taken = 1'b1;
    end else if (word[6:0] == 7'b1100011) begin
      npc   = pred_in ? pc + imm : pc + 32'd4;
      taken = pred_in;
    end else if (word[6:0] == 7'b1100111) begin
      npc  = pc;
      jalr = 1'b1;
    end
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      m_pc = RESET_PC; m_slot = 1'b0; m_can_req = 1'b1;
      m_wait = 1'b0; m_stale = 1'b0; m_jalr = 1'b0;
    end else begin
      check("cmp_icache_req", {31'b0, bus.icache_req}, {31'b0, rdy && m_can_req && !bus.flush});
      check("cmp_icache_addr", bus.icache_addr, m_pc);
      check("cmp_query_pc", bus.query_pc, m_pc);
      check("cmp_inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_slot});
      if (m_slot) begin
        check("cmp_inst", bus.inst, m_inst);
        check("cmp_inst_pc", bus.inst_pc, m_inst_pc);
        check("cmp_pred", {31'b0, bus.inst_pred_taken}, {31'b0, m_pred});
      end
      if (rdy) begin
        if (bus.flush) begin
          m_stale   = m_wait && !bus.icache_valid;
          m_can_req = !m_stale;
          m_wait    = 1'b0;
          m_slot    = 1'b0;
          m_jalr    = 1'b0;
          m_pc      = bus.flush_pc;
        end else if (m_can_req) begin
          m_can_req = 1'b0;
          m_wait    = 1'b1;
        end else if (m_wait && bus.icache_valid) begin
          model_next(m_pc, bus.icache_inst, bus.predict_result, m_npc, m_tk, m_jl);
          m_inst    = bus.icache_inst;
          m_inst_pc = m_pc;
          m_pred    = m_tk;
          m_jalr    = m_jl;
          m_pc      = m_npc;
          m_slot    = 1'b1;
          m_wait    = 1'b0;
        end else if (m_slot && bus.inst_ready) begin
          m_slot    = 1'b0;
          m_can_req = !m_jalr;
        end else if (m_stale && bus.icache_valid) begin
          m_stale   = 1'b0;
          m_can_req = 1'b1;
        end
      end
    end
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends at the falling edge of the cycle that carries the request.
  task automatic wait_req(input string name, input logic [31:0] addr, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.icache_req) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    check({name, "_req_seen"}, {31'b0, seen}, 32'd1);
    check({name, "_addr"}, bus.icache_addr, addr);
  endtask

  // Request, respond after gap cycles, check the slot, optionally accept at once.
  task automatic fetch_one(input string name, input logic [31:0] addr, input logic [31:0] word,
                           input int gap, input logic pred_in, input logic exp_taken,
                           input logic accept_now, output int lat);
    wait_req(name, addr, lat);
    repeat (gap) tick();
    bus.icache_valid   = 1'b1;
    bus.icache_inst    = word;
    bus.predict_result = pred_in;
    tick();
    bus.icache_valid   = 1'b0;
    bus.predict_result = 1'b0;
    bus.inst_ready     = accept_now;
    @(negedge clk);
    check({name, "_valid"}, {31'b0, bus.inst_valid}, 32'd1);
    check({name, "_inst_pc"}, bus.inst_pc, addr);
    check({name, "_inst"}, bus.inst, word);
    check({name, "_pred"}, {31'b0, bus.inst_pred_taken}, {31'b0, exp_taken});
    tick();
    bus.inst_ready = 1'b0;
  endtask

  // Flush from an idle fetch cycle, checking the PC it was about to use.
  task automatic redirect(input string name, input logic [31:0] exp_addr, input logic [31:0] new_pc);
    bus.flush    = 1'b1;
    bus.flush_pc = new_pc;
    @(negedge clk);
    check({name, "_next_addr"}, bus.icache_addr, exp_addr);
    check({name, "_req_masked"}, {31'b0, bus.icache_req}, 32'd0);
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] beq_m8, jal_20;
    beq_m8 = enc_b(32'hFFFF_FFF8);
    jal_20 = enc_j(32'h0000_0020);
    imm_tab[beq_m8] = 32'hFFFF_FFF8;
    imm_tab[jal_20] = 32'h0000_0020;

    bus.icache_valid = 1'b0; bus.icache_inst = '0; bus.predict_result = 1'b0;
    bus.inst_ready = 1'b0; bus.flush = 1'b0; bus.flush_pc = '0;

    // Reset values
    #2 rst = 1'b0;
    rdy = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_pred", {31'b0, bus.inst_pred_taken}, 32'd0);
    check("rst_addr", bus.icache_addr, 32'h0);
    tick();
    rst = 1'b1;

    // Sequential fetch: first request immediately, next one two cycles after the response
    fetch_one("addi0", 32'h0, ADDI1, 2, 1'b0, 1'b0, 1'b1, lat);
    check("first_req_latency", lat, 0);
    fetch_one("addi4", 32'h4, ADDI2, 1, 1'b0, 1'b0, 1'b1, lat);
    check("next_req_latency", lat, 0);

    // Branch predicted taken, then not taken
    redirect("to_beq", 32'h8, 32'h10);
    fetch_one("beq_t", 32'h10, beq_m8, 1, 1'b1, 1'b1, 1'b1, lat);
    redirect("beq_t", 32'h08, 32'h10);
    fetch_one("beq_nt", 32'h10, beq_m8, 1, 1'b0, 1'b0, 1'b1, lat);
    redirect("beq_nt", 32'h14, 32'h100);

    // JAL
    fetch_one("jal", 32'h100, jal_20, 1, 1'b0, 1'b1, 1'b1, lat);
    redirect("jal", 32'h120, 32'h40);

    // JALR stalls until the ROB redirects
    fetch_one("jalr", 32'h40, JALR1, 1, 1'b1, 1'b0, 1'b1, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("jalr_stall_no_req", {31'b0, bus.icache_req}, 32'd0);
      tick();
    end
    redirect("jalr", 32'h40, 32'h200);
    fetch_one("after_jalr", 32'h200, ADDI1, 1, 1'b0, 1'b0, 1'b1, lat);
    check("after_jalr_latency", lat, 0);
    redirect("to_drain", 32'h204, 32'h300);

    // Flush while waiting: the late response is dropped
    wait_req("drain", 32'h300, lat);
    tick();
    bus.flush = 1'b1; bus.flush_pc = 32'h80;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.icache_valid = 1'b1;
        bus.icache_inst  = jal_20;
      end
      @(negedge clk);
      check("drain_no_valid", {31'b0, bus.inst_valid}, 32'd0);
      check("drain_no_req", {31'b0, bus.icache_req}, 32'd0);
      tick();
    end
    bus.icache_valid = 1'b0;

    // Back-pressure holds the slot and blocks fetching
    fetch_one("hold", 32'h80, ADDI2, 1, 1'b0, 1'b0, 1'b0, lat);
    check("after_drain_latency", lat, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, bus.inst_valid}, 32'd1);
      check("hold_inst", bus.inst, ADDI2);
      check("hold_inst_pc", bus.inst_pc, 32'h80);
      check("hold_no_req", {31'b0, bus.icache_req}, 32'd0);
      tick();
    end

    // rdy low ignores ready and flush
    rdy = 1'b0; bus.inst_ready = 1'b1; bus.flush = 1'b1; bus.flush_pc = 32'hDEAD0;
    repeat (2) begin
      @(negedge clk);
      check("frozen_valid", {31'b0, bus.inst_valid}, 32'd1);
      tick();
    end
    rdy = 1'b1; bus.flush = 1'b0;
    tick();
    bus.inst_ready = 1'b0;
    fetch_one("after_hold", 32'h84, ADDI1, 1, 1'b0, 1'b0, 1'b0, lat);
    check("after_hold_latency", lat, 0);

    // Flush coinciding with inst_ready clears the slot instead of transferring
    bus.inst_ready = 1'b1; bus.flush = 1'b1; bus.flush_pc = 32'h500;
    tick();
    bus.inst_ready = 1'b0; bus.flush = 1'b0;
    wait_req("flush_ready", 32'h500, lat);
    check("flush_ready_slot_clear", {31'b0, bus.inst_valid}, 32'd0);

    // Flush coinciding with the response: no drain needed
    tick();
    tick();
    bus.icache_valid = 1'b1; bus.icache_inst = jal_20;
    bus.flush = 1'b1; bus.flush_pc = 32'h90;
    tick();
    bus.icache_valid = 1'b0; bus.flush = 1'b0;
    fetch_one("flush_resp", 32'h90, ADDI2, 1, 1'b0, 1'b0, 1'b1, lat);
    check("flush_resp_latency", lat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
